// File: rtl/commit_log_pkg.sv
// rtl/commit_log_pkg.sv - shared types and codes for the commit-trace log controller
//   state_t      : controller states (RUN, DRAIN, HALTED)
//   CAUSE_*      : halt_cause encodings
//   KIND_*       : log_kind encodings
//   commit_rec_t : one commit record {pc, wdata, kind} at the default 64-bit width
package commit_log_pkg;

    localparam int REC_DATA_W = 64;

    typedef enum logic [1:0] {
        ST_RUN    = 2'd0,
        ST_DRAIN  = 2'd1,
        ST_HALTED = 2'd2
    } state_t;

    localparam logic [1:0] CAUSE_NONE   = 2'd0;
    localparam logic [1:0] CAUSE_EBREAK = 2'd1;
    localparam logic [1:0] CAUSE_BADPC  = 2'd2;
    localparam logic [1:0] CAUSE_WDOG   = 2'd3;

    localparam logic KIND_NORMAL = 1'b0;
    localparam logic KIND_BADPC  = 1'b1;

    typedef struct packed {
        logic [REC_DATA_W-1:0] pc;
        logic [REC_DATA_W-1:0] wdata;
        logic                  kind;
    } commit_rec_t;

endpackage

// File: rtl/commit_log_fifo.sv
// rtl/commit_log_fifo.sv - synchronous record FIFO for the commit log
//   clock, reset        : rising-edge clock, asynchronous active-low reset
//   i_push, i_wdata     : write request and record; ignored while full unless popping the same cycle
//   i_pop               : read request; ignored while empty
//   o_rdata             : record at the read pointer (valid while !o_empty)
//   o_full, o_empty     : occupancy flags
//   o_count             : occupancy, $clog2(DEPTH)+1 bits
module commit_log_fifo #(
    parameter int WIDTH = 129,
    parameter int DEPTH = 8
) (
    input  logic                     clock,
    input  logic                     reset,
    input  logic                     i_push,
    input  logic [WIDTH-1:0]         i_wdata,
    input  logic                     i_pop,
    output logic [WIDTH-1:0]         o_rdata,
    output logic                     o_full,
    output logic                     o_empty,
    output logic [$clog2(DEPTH):0]   o_count
);

    localparam int AW    = $clog2(DEPTH);
    localparam int CNT_W = AW + 1;

    logic [WIDTH-1:0] r_mem [DEPTH];
    logic [AW-1:0]    r_wr_ptr;
    logic [AW-1:0]    r_rd_ptr;
    logic [CNT_W-1:0] r_count;
    logic             w_push;
    logic             w_pop;

    assign o_full  = (r_count == CNT_W'(DEPTH));
    assign o_empty = (r_count == '0);
    assign o_count = r_count;
    assign o_rdata = r_mem[r_rd_ptr];

    assign w_pop  = i_pop && !o_empty;
    // A full FIFO still takes a push when the head leaves in the same cycle.
    assign w_push = i_push && (!o_full || w_pop);

    always_ff @(posedge clock or negedge reset) begin
        if (!reset) begin
            r_wr_ptr <= '0;
            r_rd_ptr <= '0;
            r_count  <= '0;
            for (int i = 0; i < DEPTH; i++) begin
                r_mem[i] <= '0;
            end
        end else begin
            if (w_push) begin
                r_mem[r_wr_ptr] <= i_wdata;
                r_wr_ptr        <= r_wr_ptr + AW'(1);
            end
            if (w_pop) begin
                r_rd_ptr <= r_rd_ptr + AW'(1);
            end
            case ({w_push, w_pop})
                2'b10:   r_count <= r_count + CNT_W'(1);
                2'b01:   r_count <= r_count - CNT_W'(1);
                default: r_count <= r_count;
            endcase
        end
    end

endmodule

// File: rtl/commit_log_ctrl.sv
// rtl/commit_log_ctrl.sv - commit-trace buffer, sink drain and drain-then-halt stop control
//   clock, reset                       : rising-edge clock, asynchronous active-low reset
//   commit_valid/pc/wdata, ebreak      : commit stage inputs
//   log_valid/ready/pc/wdata/kind      : record stream to the log sink
//   halt, halt_cause                   : sticky stop request and its reason
//   heartbeat                          : one-cycle progress pulse (built only with COMMIT_LOG_HEARTBEAT_EN)
//   drop_count                         : saturating count of commits lost to a full FIFO
module commit_log_ctrl
    import commit_log_pkg::*;
#(
    parameter int                 DATA_W     = 64,
    parameter int                 DEPTH      = 8,
    parameter logic [DATA_W-1:0]  PC_LOW     = DATA_W'(64'h3000_0000),
    parameter logic [31:0]        WDOG_LIMIT = 32'd400_000_000,
    parameter logic [31:0]        HB_PERIOD  = 32'h0030_0000
) (
    input  logic              clock,
    input  logic              reset,
    input  logic              commit_valid,
    input  logic [DATA_W-1:0] commit_pc,
    input  logic [DATA_W-1:0] commit_wdata,
    input  logic              ebreak,
    output logic              log_valid,
    input  logic              log_ready,
    output logic [DATA_W-1:0] log_pc,
    output logic [DATA_W-1:0] log_wdata,
    output logic              log_kind,
    output logic              halt,
    output logic [1:0]        halt_cause,
    output logic              heartbeat,
    output logic [15:0]       drop_count
);

    localparam int REC_W = 2 * DATA_W + 1;
    localparam int CNT_W = $clog2(DEPTH) + 1;

    state_t           r_state;
    logic             r_halt;
    logic [1:0]       r_halt_cause;
    logic [15:0]      r_drop_count;
    logic [31:0]      r_wdog_cnt;

    logic             w_run;
    logic             w_kind;
    logic             w_push;
    logic             w_pop;
    logic             w_drop;
    logic             w_full;
    logic             w_empty;
    logic             w_last_pop;
    logic [CNT_W-1:0] w_count;
    logic [REC_W-1:0] w_rdata;

    assign w_run  = (r_state == ST_RUN);
    assign w_kind = (commit_pc < PC_LOW) ? KIND_BADPC : KIND_NORMAL;
    assign w_push = w_run && commit_valid;
    assign w_pop  = log_valid && log_ready;
    assign w_drop = w_push && w_full && !w_pop;
    // True when the FIFO is empty after this edge; no pushes happen while draining.
    assign w_last_pop = w_empty || ((w_count == CNT_W'(1)) && w_pop);

    commit_log_fifo #(
        .WIDTH (REC_W),
        .DEPTH (DEPTH)
    ) u_fifo (
        .clock   (clock),
        .reset   (reset),
        .i_push  (w_push),
        .i_wdata ({commit_pc, commit_wdata, w_kind}),
        .i_pop   (w_pop),
        .o_rdata (w_rdata),
        .o_full  (w_full),
        .o_empty (w_empty),
        .o_count (w_count)
    );

    assign log_valid  = !w_empty;
    assign log_pc     = w_rdata[REC_W-1 -: DATA_W];
    assign log_wdata  = w_rdata[DATA_W:1];
    assign log_kind   = w_rdata[0];
    assign halt       = r_halt;
    assign halt_cause = r_halt_cause;
    assign drop_count = r_drop_count;

    always_ff @(posedge clock or negedge reset) begin
        if (!reset) begin
            r_state      <= ST_RUN;
            r_halt       <= 1'b0;
            r_halt_cause <= CAUSE_NONE;
            r_drop_count <= '0;
            r_wdog_cnt   <= '0;
        end else begin
            case (r_state)
                ST_RUN: begin
                    r_wdog_cnt <= r_wdog_cnt + 32'd1;
                    if (w_drop && (r_drop_count != 16'hFFFF)) begin
                        r_drop_count <= r_drop_count + 16'd1;
                    end
                    if (commit_valid && (w_kind == KIND_BADPC)) begin
                        r_halt_cause <= CAUSE_BADPC;
                        r_state      <= ST_DRAIN;
                    end else if (ebreak) begin
                        r_halt_cause <= CAUSE_EBREAK;
                        r_state      <= ST_DRAIN;
                    end else if (r_wdog_cnt >= WDOG_LIMIT) begin
                        r_halt_cause <= CAUSE_WDOG;
                        r_state      <= ST_DRAIN;
                    end
                end
                ST_DRAIN: begin
                    if (w_last_pop) begin
                        r_state <= ST_HALTED;
                        r_halt  <= 1'b1;
                    end
                end
                ST_HALTED: begin
                    r_halt <= 1'b1;
                end
                default: begin
                    r_state <= ST_HALTED;
                    r_halt  <= 1'b1;
                end
            endcase
        end
    end

`ifdef COMMIT_LOG_HEARTBEAT_EN
    logic [31:0] r_hb_cnt;
    logic        r_heartbeat;

    always_ff @(posedge clock or negedge reset) begin
        if (!reset) begin
            r_hb_cnt    <= '0;
            r_heartbeat <= 1'b0;
        end else begin
            r_heartbeat <= 1'b0;
            if (w_run) begin
                if (r_hb_cnt == HB_PERIOD - 32'd1) begin
                    r_hb_cnt    <= '0;
                    r_heartbeat <= 1'b1;
                end else begin
                    r_hb_cnt <= r_hb_cnt + 32'd1;
                end
            end
        end
    end

    assign heartbeat = r_heartbeat;
`else
    logic w_unused_hb_period;
    assign w_unused_hb_period = ^HB_PERIOD;
    assign heartbeat          = 1'b0;
`endif

endmodule

// File: doc/commit_log_ctrl.md
# commit_log_ctrl

Sequences the simulation commit-trace path between the core's commit stage and the log sink. Buffers per-instruction commit records in a small FIFO, drains them to the sink over a valid/ready handshake, and owns the stop decision: ebreak, out-of-range PC and watchdog timeout all trigger an orderly drain-then-halt. It also emits a periodic progress heartbeat.

## Interface
Parameters:
- DATA_W, 64, width of pc and write-data fields
- DEPTH, 8, FIFO entries (power of two, ≥2)
- PC_LOW, 64'h3000_0000, lowest legal commit PC
- WDOG_LIMIT, 400_000_000, cycles before watchdog halt
- HB_PERIOD, 32'h0030_0000, cycles between heartbeat pulses

Ports:
- clock  input  1  single clock, rising edge
- reset  input  1  asynchronous, active-low reset
- commit_valid  input  1  one instruction committed this cycle
- commit_pc  input  DATA_W  committed PC
- commit_wdata  input  DATA_W  committed write data
- ebreak  input  1  core executed ebreak
- log_valid  output  1  record available to sink
- log_ready  input  1  sink accepts record
- log_pc  output  DATA_W  record PC
- log_wdata  output  DATA_W  record write data
- log_kind  output  1  0 = normal, 1 = bad-PC record
- halt  output  1  sticky stop request to testbench
- halt_cause  output  2  0 none, 1 ebreak, 2 bad PC, 3 watchdog
- heartbeat  output  1  one-cycle progress pulse
- drop_count  output  16  saturating count of records lost to full FIFO

## Operation
- States: RUN, DRAIN, HALTED.
- RUN: each commit_valid pushes {pc, wdata, kind}; kind = 1 when commit_pc < PC_LOW (unsigned).
- Push accepted when count < DEPTH or a pop occurs the same cycle; otherwise record dropped, drop_count += 1 (saturates at 16'hFFFF).
- Halt triggers in RUN, priority bad-PC > ebreak > watchdog; the winner latches halt_cause, state → DRAIN. The triggering cycle's commit is still pushed.
- Watchdog: 32-bit cycle counter from reset; trigger when counter ≥ WDOG_LIMIT. Counter stops once outside RUN.
- DRAIN: commits ignored (not counted as drops); sink keeps draining. When FIFO empty → HALTED.
- HALTED: halt = 1 and halt_cause held until reset; log_valid = 0.
- Triggers in DRAIN/HALTED are ignored; cause never overwritten.

## Timing
- Reset values: log_valid 0, log_pc/log_wdata 0, log_kind 0, halt 0, halt_cause 0, heartbeat 0, drop_count 0, state RUN, counters 0.
- Push at edge N → log_valid high after edge N (1-cycle latency) if FIFO was empty.
- Pop on log_valid & log_ready at a rising edge; log_* stable while log_valid & !log_ready.
- DRAIN → HALTED at the edge where count becomes 0; halt visible the next cycle. Trigger with empty FIFO: RUN → DRAIN → HALTED, halt asserted 2 cycles after trigger edge.
- Pointers wrap modulo DEPTH; count is $clog2(DEPTH)+1 bits.
- Reset asserted mid-drain: FIFO flushed, all outputs to reset values immediately (asynchronous).

## Configuration
- COMMIT_LOG_HEARTBEAT_EN defined: heartbeat counter built; heartbeat pulses one cycle every HB_PERIOD cycles while in RUN.
- Not defined: no heartbeat counter; heartbeat tied to 0.

## Structure
- Package commit_log_pkg: state enum (RUN, DRAIN, HALTED), halt-cause codes, log_kind codes, record struct {pc, wdata, kind}.
- One sub-module: commit_log_fifo (synchronous FIFO, DEPTH entries, push/pop/full/empty/count, async active-low reset).

## Test plan
- 3 commits pc 0x8000_0000..0x8000_0008, log_ready = 1 → three records in order, each 1 cycle after push, kind 0, halt 0.
- log_ready = 0, 10 back-to-back commits, DEPTH = 8 → 8 buffered, drop_count = 2; releasing ready drains first 8 in order.
- Commit pc 0x2FFF_FFFC plus ebreak same cycle → halt_cause = 2, record kind 1 emitted, halt after FIFO empty.
- ebreak with 4 queued records, ready toggling 1/0 → all 4 drained, then halt = 1, halt_cause = 1; later commits not logged, drop_count unchanged.
- WDOG_LIMIT = 100, no ebreak → halt_cause = 3, halt high at cycle 102; with COMMIT_LOG_HEARTBEAT_EN and HB_PERIOD = 16, heartbeat pulses at 16, 32, 48, ….
- Reset deasserted→asserted during DRAIN with 3 records queued → log_valid, halt, drop_count immediately 0; new commits after release logged normally.
